// File: rtl/file_rmw_master.sv
// Read-modify-write master for a 2-read/1-write register file: ADD/SUB/XOR of
// two entries into a third, plus a CLEAR sweep that zeroes MEM_DEPTH entries.
module file_rmw_master #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_op_in,
  input  logic [7:0]  cmd_src0_in,
  input  logic [7:0]  cmd_src1_in,
  input  logic [7:0]  cmd_dst_in,
  output logic [7:0]  read_addr0_out,
  output logic [7:0]  read_addr1_out,
  output logic        read_out,
  input  logic [31:0] read_data0_in,
  input  logic [31:0] read_data1_in,
  output logic [7:0]  write_addr_out,
  output logic        write_out,
  output logic [31:0] write_data_out,
  output logic        result_valid_out,
  output logic [31:0] result_data_out,
  output logic        busy_out,
  input  logic        debugen_in
);
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  op_r;
  logic [7:0]  src0_r;
  logic [7:0]  src1_r;
  logic [7:0]  dst_r;
  logic [31:0] op0_r;
  logic [31:0] op1_r;
  logic [7:0]  clr_cnt_r;
  logic [31:0] result_s;
  logic        unused_debugen_s;

  function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Debug tracing is a simulation-side concern; the synthesizable core ignores it.
  assign unused_debugen_s = debugen_in;
  assign result_s = alu(op_r, op0_r, op1_r);

  // Command FSM: latches the command, samples operands, walks the CLEAR counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'b00;
      src0_r    <= 8'd0;
      src1_r    <= 8'd0;
      dst_r     <= 8'd0;
      op0_r     <= 32'd0;
      op1_r     <= 32'd0;
      clr_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_in) begin
            op_r      <= cmd_op_in;
            src0_r    <= cmd_src0_in;
            src1_r    <= cmd_src1_in;
            dst_r     <= cmd_dst_in;
            clr_cnt_r <= 8'd0;
            state_r   <= (cmd_op_in == OP_CLEAR) ? ST_CLEAR : ST_READ;
          end
        end
        ST_READ: begin
          op0_r   <= read_data0_in;
          op1_r   <= read_data1_in;
          state_r <= ST_WRITE;
        end
        ST_WRITE: begin
          state_r <= ST_IDLE;
        end
        ST_CLEAR: begin
          if (clr_cnt_r == LAST_ADDR) begin
            clr_cnt_r <= 8'd0;
            state_r   <= ST_IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state; reset forces every output low.
  always_comb begin
    cmd_ready_out    = 1'b0;
    busy_out         = 1'b0;
    read_out         = 1'b0;
    read_addr0_out   = 8'd0;
    read_addr1_out   = 8'd0;
    write_out        = 1'b0;
    write_addr_out   = 8'd0;
    write_data_out   = 32'd0;
    result_valid_out = 1'b0;
    result_data_out  = 32'd0;
    if (!reset) begin
      busy_out = (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          cmd_ready_out = 1'b1;
        end
        ST_READ: begin
          read_out       = 1'b1;
          read_addr0_out = src0_r;
          read_addr1_out = src1_r;
        end
        ST_WRITE: begin
          write_out        = 1'b1;
          write_addr_out   = dst_r;
          write_data_out   = result_s;
          result_valid_out = 1'b1;
          result_data_out  = result_s;
        end
        ST_CLEAR: begin
          write_out      = 1'b1;
          write_addr_out = clr_cnt_r;
          write_data_out = 32'd0;
        end
        default: begin
          cmd_ready_out = 1'b0;
        end
      endcase
    end else begin
      busy_out = 1'b0;
    end
  end
endmodule

// File: tb/tb_file_rmw_master.sv
// Directed bench for file_rmw_master: table of RMW vectors against a file
// model, plus hand sequences for back-to-back, CLEAR and reset corners.
module tb_file_rmw_master;
  logic        clk;
  logic        reset;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [1:0]  cmd_op_in;
  logic [7:0]  cmd_src0_in;
  logic [7:0]  cmd_src1_in;
  logic [7:0]  cmd_dst_in;
  logic [7:0]  read_addr0_out;
  logic [7:0]  read_addr1_out;
  logic        read_out;
  logic [31:0] read_data0_in;
  logic [31:0] read_data1_in;
  logic [7:0]  write_addr_out;
  logic        write_out;
  logic [31:0] write_data_out;
  logic        result_valid_out;
  logic [31:0] result_data_out;
  logic        busy_out;
  logic        debugen_in;

  logic [31:0] mem [256];
  int          tests;
  int          fails;
  int          wr_count;
  logic        clear_active;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [7:0]  d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  file_rmw_master #(.MEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_src0_in(cmd_src0_in),
    .cmd_src1_in(cmd_src1_in), .cmd_dst_in(cmd_dst_in),
    .read_addr0_out(read_addr0_out), .read_addr1_out(read_addr1_out),
    .read_out(read_out), .read_data0_in(read_data0_in),
    .read_data1_in(read_data1_in), .write_addr_out(write_addr_out),
    .write_out(write_out), .write_data_out(write_data_out),
    .result_valid_out(result_valid_out), .result_data_out(result_data_out),
    .busy_out(busy_out), .debugen_in(debugen_in)
  );

  assign read_data0_in = mem[read_addr0_out];
  assign read_data1_in = mem[read_addr1_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // One clock: sample the write port mid-cycle, commit it to the file at the edge.
  task automatic tick();
    logic        w;
    logic [7:0]  wa;
    logic [31:0] wd;
    @(negedge clk);
    w  = write_out;
    wa = write_addr_out;
    wd = write_data_out;
    @(posedge clk);
    if (w) begin
      mem[wa] = wd;
      wr_count++;
    end
    #1;
  endtask

  function automatic logic any_output_high();
    return |{cmd_ready_out, read_out, write_out, result_valid_out, busy_out,
             read_addr0_out, read_addr1_out, write_addr_out, write_data_out,
             result_data_out};
  endfunction

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      chk1("ready_eq_not_busy", cmd_ready_out, ~busy_out);
      chk1("rd_wr_exclusive", read_out & write_out, 1'b0);
      if (!clear_active) begin
        chk1("rvalid_eq_write", result_valid_out, write_out);
      end
    end
  end

  initial begin
    int found_at;
    int bad;
    int w0;
    tests = 0; fails = 0; wr_count = 0; clear_active = 1'b0;
    reset = 1'b1; debugen_in = 1'b0;
    cmd_valid_in = 1'b0; cmd_op_in = 2'b00;
    cmd_src0_in = 8'd0; cmd_src1_in = 8'd0; cmd_dst_in = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    vecs[0] = '{op:2'b00, s0:8'd1,   s1:8'd2,  d:8'd4,   a:32'h0000_0005, b:32'h0000_0003, exp:32'h0000_0008};
    vecs[1] = '{op:2'b01, s0:8'd1,   s1:8'd2,  d:8'd7,   a:32'h0000_0000, b:32'h0000_0001, exp:32'hFFFF_FFFF};
    vecs[2] = '{op:2'b10, s0:8'd7,   s1:8'd7,  d:8'd7,   a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, exp:32'h0000_0000};
    vecs[3] = '{op:2'b00, s0:8'd5,   s1:8'd5,  d:8'd5,   a:32'h8000_0001, b:32'h8000_0001, exp:32'h0000_0002};
    vecs[4] = '{op:2'b01, s0:8'd9,   s1:8'd10, d:8'd11,  a:32'h1234_5678, b:32'h0234_5678, exp:32'h1000_0000};
    vecs[5] = '{op:2'b10, s0:8'd255, s1:8'd0,  d:8'd255, a:32'hA5A5_A5A5, b:32'h0F0F_0F0F, exp:32'hAAAA_AAAA};
    vecs[6] = '{op:2'b00, s0:8'd20,  s1:8'd21, d:8'd22,  a:32'hFFFF_FFFF, b:32'h0000_0001, exp:32'h0000_0000};

    // Reset: every output gated low.
    tick();
    tick();
    chk1("reset_outputs_zero", any_output_high(), 1'b0);
    reset = 1'b0;

    // Table of RMW commands; the first is accepted on the first edge out of reset.
    for (int i = 0; i < NV; i++) begin
      mem[vecs[i].s0] = vecs[i].a;
      mem[vecs[i].s1] = vecs[i].b;
      cmd_valid_in = 1'b1; cmd_op_in = vecs[i].op;
      cmd_src0_in = vecs[i].s0; cmd_src1_in = vecs[i].s1; cmd_dst_in = vecs[i].d;
      #1;
      chk1($sformatf("v%0d_ready_idle", i), cmd_ready_out, 1'b1);
      tick();
      cmd_valid_in = 1'b0;
      chk1($sformatf("v%0d_read_strobe", i), read_out, 1'b1);
      chk($sformatf("v%0d_read_addr0", i), {24'd0, read_addr0_out}, {24'd0, vecs[i].s0});
      chk($sformatf("v%0d_read_addr1", i), {24'd0, read_addr1_out}, {24'd0, vecs[i].s1});
      chk1($sformatf("v%0d_busy_read", i), busy_out, 1'b1);
      chk1($sformatf("v%0d_no_write_in_read", i), write_out, 1'b0);
      tick();
      chk1($sformatf("v%0d_write_strobe", i), write_out, 1'b1);
      chk($sformatf("v%0d_write_addr", i), {24'd0, write_addr_out}, {24'd0, vecs[i].d});
      chk($sformatf("v%0d_write_data", i), write_data_out, vecs[i].exp);
      chk1($sformatf("v%0d_result_valid", i), result_valid_out, 1'b1);
      chk($sformatf("v%0d_result_data", i), result_data_out, vecs[i].exp);
      chk($sformatf("v%0d_read_addr_idle_zero", i), {16'd0, read_addr0_out, read_addr1_out}, 32'd0);
      tick();
      chk1($sformatf("v%0d_ready_again", i), cmd_ready_out, 1'b1);
      chk1($sformatf("v%0d_write_done", i), write_out, 1'b0);
      chk($sformatf("v%0d_idle_write_port_zero", i), write_data_out | {24'd0, write_addr_out}, 32'd0);
      chk($sformatf("v%0d_file_dst", i), mem[vecs[i].d], vecs[i].exp);
    end

    // Back-to-back: second ADD reads r3 written by the first.
    mem[1] = 32'd10; mem[2] = 32'd20; mem[6] = 32'd7;
    cmd_valid_in = 1'b1; cmd_op_in = 2'b00;
    cmd_src0_in = 8'd1; cmd_src1_in = 8'd2; cmd_dst_in = 8'd3;
    tick();
    cmd_src0_in = 8'd3; cmd_src1_in = 8'd6; cmd_dst_in = 8'd8;
    found_at = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (read_out && read_addr0_out == 8'd3) begin
        found_at = n;
        break;
      end
    end
    cmd_valid_in = 1'b0;
    chk("b2b_accept_spacing", found_at, 32'd3);
    chk("b2b_first_result", mem[3], 32'd30);
    tick();
    chk("b2b_second_write_data", write_data_out, 32'd37);
    tick();
    chk("b2b_file_r8", mem[8], 32'd37);

    // Full CLEAR sweep over a non-zero file.
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    clear_active = 1'b1;
    cmd_valid_in = 1'b1; cmd_op_in = 2'b11;
    tick();
    cmd_valid_in = 1'b0;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (!write_out || write_addr_out != 8'(k) || write_data_out != 32'd0 ||
          cmd_ready_out || result_valid_out || read_out) bad++;
      tick();
    end
    chk("clear_bad_cycles", bad, 32'd0);
    chk1("clear_ready_257th", cmd_ready_out, 1'b1);
    chk1("clear_write_stops", write_out, 1'b0);
    clear_active = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 32'd0) bad++;
    chk("clear_nonzero_entries", bad, 32'd0);

    // Reset during the READ cycle of an ADD: no write may follow.
    mem[1] = 32'd1; mem[2] = 32'd2; mem[12] = 32'hDEAD_BEEF;
    cmd_valid_in = 1'b1; cmd_op_in = 2'b00;
    cmd_src0_in = 8'd1; cmd_src1_in = 8'd2; cmd_dst_in = 8'd12;
    tick();
    cmd_valid_in = 1'b0;
    chk1("rst_read_in_read", read_out, 1'b1);
    w0 = wr_count;
    reset = 1'b1;
    #1;
    chk1("rst_read_outputs_zero", any_output_high(), 1'b0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_read_no_write", wr_count - w0, 32'd0);
    chk("rst_read_dst_untouched", mem[12], 32'hDEAD_BEEF);
    chk1("rst_read_not_busy", busy_out, 1'b0);

    // Reset mid-CLEAR at counter 10: entries 10..255 keep their contents.
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    clear_active = 1'b1;
    cmd_valid_in = 1'b1; cmd_op_in = 2'b11;
    tick();
    cmd_valid_in = 1'b0;
    found_at = 0;
    for (int n = 0; n < 20; n++) begin
      if (write_out && write_addr_out == 8'd10) begin
        found_at = 1;
        break;
      end
      tick();
    end
    chk("midclr_reached_cnt10", found_at, 32'd1);
    reset = 1'b1;
    #1;
    chk1("midclr_outputs_zero", any_output_high(), 1'b0);
    w0 = wr_count;
    tick();
    reset = 1'b0;
    clear_active = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    chk("midclr_no_more_writes", wr_count - w0, 32'd0);
    chk1("midclr_not_busy", busy_out, 1'b0);
    chk1("midclr_ready", cmd_ready_out, 1'b1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < 10 && mem[i] != 32'd0) bad++;
      if (i >= 10 && mem[i] != 32'(i + 1)) bad++;
    end
    chk("midclr_entry_errors", bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/file_rmw_master.md
FILE_RMW_MASTER -- requirements
Module: file_rmw_master

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of file entries swept by CLEAR; legal range 1..256.
REQ-002 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid_in  input  1  command offered.
REQ-005 cmd_ready_out  output  1  command accepted when both valid and ready are high on a rising edge.
REQ-006 cmd_op_in  input  2  00 ADD, 01 SUB, 10 XOR, 11 CLEAR.
REQ-007 cmd_src0_in, cmd_src1_in, cmd_dst_in  input  8 each  operand and destination addresses.
REQ-008 read_addr0_out, read_addr1_out  output  8 each  file read addresses.
REQ-009 read_out  output  1  read strobe.
REQ-010 read_data0_in, read_data1_in  input  32 each  file read data; combinational from the read addresses, same cycle.
REQ-011 write_addr_out  output  8; write_out  output  1; write_data_out  output  32  file write port; the file captures the write on the edge where write_out=1.
REQ-012 result_valid_out  output  1; result_data_out  output  32  one-cycle result report.
REQ-013 busy_out  output  1  high in any state other than IDLE.
REQ-014 debugen_in  input  1  when high, print state, command and file-port activity once per cycle (simulation only).

Function
REQ-015 FSM states: IDLE, READ, WRITE, CLEAR.
REQ-016 IDLE: cmd_ready_out=1. On accept, latch op, src0, src1 and dst. Go to CLEAR if op=11; otherwise go to READ.
REQ-017 READ (exactly 1 cycle): read_out=1, read_addr0_out=src0, read_addr1_out=src1. Capture read_data0_in/read_data1_in into operand registers at the cycle-ending edge. Go to WRITE.
REQ-018 WRITE (exactly 1 cycle): write_out=1, write_addr_out=dst, write_data_out=result. result_valid_out=1 and result_data_out=result in the same cycle. Go to IDLE.
REQ-019 Result: ADD = op0+op1 mod 2^32; SUB = op0-op1 mod 2^32; XOR = op0^op1. No carry, borrow or overflow outputs.
REQ-020 Latency: command accepted at edge T; READ in cycle T..T+1; WRITE in cycle T+1..T+2; cmd_ready_out high again in cycle T+2..T+3. Peak throughput is one RMW per 3 cycles.
REQ-021 CLEAR: a counter starts at 0. Each CLEAR cycle drives write_out=1, write_addr_out=counter, write_data_out=0, then increments the counter. After the cycle with counter=MEM_DEPTH-1, go to IDLE. CLEAR lasts exactly MEM_DEPTH cycles. result_valid_out stays 0.
REQ-022 When write_out=0: write_addr_out and write_data_out SHALL be 0. When read_out=0: read addresses SHALL be 0.
REQ-023 cmd_ready_out SHALL be 0 in every state other than IDLE. Commands offered while busy are neither consumed nor lost; valid/data held by the sender are taken on return to IDLE.
REQ-024 src0, src1 and dst may be equal, e.g. ADD r5=r5+r5. Operands are sampled in READ, before the WRITE, so no hazard exists.
REQ-025 Back-to-back commands whose src equals the previous dst SHALL read the already-written value, because the write edge precedes the next READ.

Reset
REQ-026 While reset=1, all outputs SHALL be 0: cmd_ready_out, read_out, write_out, result_valid_out, busy_out, all addresses and data. This is combinational gating by reset.
REQ-027 A reset edge SHALL force IDLE and clear the operand registers, the latched command and the CLEAR counter.
REQ-028 Reset mid-operation abandons the operation. No write is issued in or after the reset cycle. A CLEAR interrupted by reset is not resumed.
REQ-029 The first command can be accepted on the first edge with reset=0.

Verification
REQ-030 Preload file r1=0x00000005, r2=0x00000003. Issue ADD src0=1 src1=2 dst=4 -> READ cycle has read_addr0_out=1, read_addr1_out=2; next cycle write_out=1, write_addr_out=4, write_data_out=0x00000008, result_valid_out=1.
REQ-031 With r1=0, r2=1, SUB dst=7 -> write_data_out=0xFFFFFFFF. Then XOR src0=7 src1=7 dst=7 -> r7=0.
REQ-032 With MEM_DEPTH=256, issue CLEAR -> 256 consecutive writes to addresses 0x00..0xFF, all data 0. cmd_ready_out is low throughout and high on the 257th cycle after accept. Every file entry reads 0 afterwards.
REQ-033 Hold cmd_valid_in high with two queued commands, ADD dst=3 followed by ADD src0=3 -> the second is accepted exactly 3 cycles after the first and reads the updated r3.
REQ-034 Assert reset in the READ cycle of an ADD -> no write_out pulse occurs. After reset all outputs are 0 and busy_out=0. Assert reset mid-CLEAR at counter=10 -> writes stop and entries 10..255 are untouched.
REQ-035 The bench SHALL check continuously: cmd_ready_out==!busy_out outside reset; write_out and read_out are never high in the same cycle; result_valid_out==write_out outside CLEAR.
